// File: rtl/prey_manager_if.sv
// Signal bundle between the game logic and prey_manager: head/pixel/random inputs, prey state outputs.
// master drives the inputs and observes the prey outputs; slave is the prey_manager side.
interface prey_manager_if;
  logic        game_en;
  logic [9:0]  rand_X;
  logic [8:0]  rand_Y;
  logic [9:0]  head_X;
  logic [8:0]  head_Y;
  logic        head_valid;
  logic [9:0]  pixel_X;
  logic [8:0]  pixel_Y;
  logic [9:0]  prey_X;
  logic [8:0]  prey_Y;
  logic        prey_valid;
  logic        eaten;
  logic [11:0] score;
  logic        prey_pixel;

  modport master (
    output game_en, rand_X, rand_Y, head_X, head_Y, head_valid, pixel_X, pixel_Y,
    input  prey_X, prey_Y, prey_valid, eaten, score, prey_pixel
  );

  modport slave (
    input  game_en, rand_X, rand_Y, head_X, head_Y, head_valid, pixel_X, pixel_Y,
    output prey_X, prey_Y, prey_valid, eaten, score, prey_pixel
  );
endinterface

// File: rtl/prey_manager.sv
// Places one prey at a time from random candidates, detects the head eating it and keeps a BCD score.
// All outputs registered: a prey is placed the cycle after a legal sample, eaten/score follow a hit by one cycle.
module prey_manager #(
  parameter int PREY_SIZE     = 10,
  parameter int X_MIN         = 40,
  parameter int X_MAX         = 570,
  parameter int Y_MIN         = 40,
  parameter int Y_MAX         = 400,
  parameter int RESPAWN_TRIES = 8
) (
  input logic             clk_d,
  input logic             rst,
  prey_manager_if.slave   bus
);

  localparam int TW = $clog2(RESPAWN_TRIES + 1);
  localparam logic [10:0] SZ_X   = 11'(PREY_SIZE);
  localparam logic [9:0]  SZ_Y   = 10'(PREY_SIZE);
  localparam logic [10:0] XMIN_W = 11'(X_MIN);
  localparam logic [10:0] XMAX_W = 11'(X_MAX);
  localparam logic [9:0]  YMIN_W = 10'(Y_MIN);
  localparam logic [9:0]  YMAX_W = 10'(Y_MAX);
  localparam logic [9:0]  FB0_X  = 10'(X_MIN);
  localparam logic [8:0]  FB0_Y  = 9'(Y_MIN);
  localparam logic [9:0]  FB1_X  = 10'(X_MAX - PREY_SIZE);
  localparam logic [8:0]  FB1_Y  = 9'(Y_MAX - PREY_SIZE);

  typedef enum logic [1:0] {EMPTY, SPAWN, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [TW-1:0] tries, tries_nxt;
  logic [9:0]  prey_x, prey_x_nxt;
  logic [8:0]  prey_y, prey_y_nxt;
  logic        prey_vld, prey_vld_nxt;
  logic        eaten, eaten_nxt;
  logic [11:0] score, score_nxt;
  logic        prey_pix;

  // Widened by one bit so x+PREY_SIZE / y+PREY_SIZE never wrap.
  function automatic logic overlap(input logic [9:0] ax, input logic [8:0] ay,
                                   input logic [9:0] bx, input logic [8:0] by);
    logic [10:0] axw, bxw;
    logic [9:0]  ayw, byw;
    axw = {1'b0, ax};
    bxw = {1'b0, bx};
    ayw = {1'b0, ay};
    byw = {1'b0, by};
    return (axw < bxw + SZ_X) && (bxw < axw + SZ_X) &&
           (ayw < byw + SZ_Y) && (byw < ayw + SZ_Y);
  endfunction

  function automatic logic [11:0] bcd_inc(input logic [11:0] s);
    logic [3:0] d0, d1, d2;
    d0 = s[3:0];
    d1 = s[7:4];
    d2 = s[11:8];
    if (s != 12'h999) begin
      if (d0 != 4'd9) d0 = d0 + 4'd1;
      else begin
        d0 = 4'd0;
        if (d1 != 4'd9) d1 = d1 + 4'd1;
        else begin
          d1 = 4'd0;
          d2 = d2 + 4'd1;
        end
      end
    end
    return {d2, d1, d0};
  endfunction

  logic in_bounds, legal, fb_blocked, hit, last_try;

  assign in_bounds  = ({1'b0, bus.rand_X} >= XMIN_W) && ({1'b0, bus.rand_X} + SZ_X <= XMAX_W) &&
                      ({1'b0, bus.rand_Y} >= YMIN_W) && ({1'b0, bus.rand_Y} + SZ_Y <= YMAX_W);
  assign legal      = in_bounds && !overlap(bus.rand_X, bus.rand_Y, bus.head_X, bus.head_Y);
  assign fb_blocked = overlap(FB0_X, FB0_Y, bus.head_X, bus.head_Y);
  assign hit        = bus.head_valid && bus.game_en && overlap(bus.head_X, bus.head_Y, prey_x, prey_y);
  assign last_try   = (tries == TW'(RESPAWN_TRIES - 1));

  always_ff @(posedge clk_d) begin
    if (rst) begin
      state    <= EMPTY;
      tries    <= '0;
      prey_x   <= '0;
      prey_y   <= '0;
      prey_vld <= 1'b0;
      eaten    <= 1'b0;
      score    <= '0;
      prey_pix <= 1'b0;
    end else begin
      state    <= state_nxt;
      tries    <= tries_nxt;
      prey_x   <= prey_x_nxt;
      prey_y   <= prey_y_nxt;
      prey_vld <= prey_vld_nxt;
      eaten    <= eaten_nxt;
      score    <= score_nxt;
      prey_pix <= prey_vld &&
                  ({1'b0, bus.pixel_X} >= {1'b0, prey_x}) && ({1'b0, bus.pixel_X} < {1'b0, prey_x} + SZ_X) &&
                  ({1'b0, bus.pixel_Y} >= {1'b0, prey_y}) && ({1'b0, bus.pixel_Y} < {1'b0, prey_y} + SZ_Y);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (bus.game_en) state_nxt = SPAWN;
      SPAWN:   if (bus.game_en && (legal || last_try)) state_nxt = ACTIVE;
      ACTIVE:  if (hit) state_nxt = SPAWN;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    tries_nxt    = tries;
    prey_x_nxt   = prey_x;
    prey_y_nxt   = prey_y;
    prey_vld_nxt = prey_vld;
    eaten_nxt    = 1'b0;
    score_nxt    = score;
    if (state == SPAWN && bus.game_en) begin
      if (legal) begin
        prey_x_nxt   = bus.rand_X;
        prey_y_nxt   = bus.rand_Y;
        prey_vld_nxt = 1'b1;
        tries_nxt    = '0;
      end else if (last_try) begin
        prey_x_nxt   = fb_blocked ? FB1_X : FB0_X;
        prey_y_nxt   = fb_blocked ? FB1_Y : FB0_Y;
        prey_vld_nxt = 1'b1;
        tries_nxt    = '0;
      end else begin
        tries_nxt = tries + TW'(1);
      end
    end else if (state == ACTIVE && hit) begin
      eaten_nxt    = 1'b1;
      prey_vld_nxt = 1'b0;
      score_nxt    = bcd_inc(score);
    end
  end

  assign bus.prey_X     = prey_x;
  assign bus.prey_Y     = prey_y;
  assign bus.prey_valid = prey_vld;
  assign bus.eaten      = eaten;
  assign bus.score      = score;
  assign bus.prey_pixel = prey_pix;

endmodule
